cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 The module SHALL have parameter Max, default 15, giving the upper wrap bound of the shared counter (0..15, Max > Min).
REQ-002 The module SHALL have parameter Min, default 0, giving the lower wrap bound of the shared counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-005 The module SHALL have port req, input, 2 bits: per-requester burst request, level-sensitive.
REQ-006 The module SHALL have port dir0 / dir1, input, 1 bit each: per-requester count direction (1 = up, 0 = down).
REQ-007 The module SHALL have port len0 / len1, input, 4 bits each: per-requester burst length in steps (0..15).
REQ-008 The module SHALL have port gnt, output, 2 bits: one-hot, one-cycle grant pulse.
REQ-009 The module SHALL have port done, output, 2 bits: one-hot, one-cycle burst-complete pulse.
REQ-010 The module SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-011 The module SHALL have port owner, output, 1 bit: index of the current or most recent grantee.
REQ-012 The module SHALL have port cnt, output, 4 bits: shared counter value.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE with req != 0, the FSM SHALL select the winner at the clock edge and latch the winner's dir, len and owner index.
- Next state: RUN if len != 0, else DONE.
- gnt[winner] high for exactly the following cycle.
REQ-015 Arbitration SHALL be round-robin.
- Single requester: that requester wins.
- Both requesting: the requester not granted last wins.
- After reset, requester 0 has priority.
REQ-016 In RUN, each edge SHALL step cnt once in the latched direction and decrement the remaining-step count; the edge performing the final step moves the FSM to DONE.
REQ-017 Stepping up from cnt == Max SHALL wrap to Min; stepping down from cnt == Min SHALL wrap to Max; all other steps are +1 or -1, modulo 4 bits.
REQ-018 In DONE, done[owner] SHALL be high for that one cycle; the next edge returns the FSM to IDLE; cnt holds.
REQ-019 A burst of length L accepted at edge k SHALL have these cycle-level effects:
- gnt high during cycle k..k+1.
- cnt changes at edges k+1 .. k+L.
- done high during the cycle after edge k+L (L=0: the cycle after edge k+1).
- The next grant occurs no earlier than edge k+L+2.
REQ-020 Changes to req, dir or len after acceptance SHALL be ignored until the FSM is back in IDLE; a burst is never aborted by req deassertion.
REQ-021 cnt SHALL change only in RUN; gnt and done SHALL never be asserted in the same cycle, and each SHALL have at most one bit set.
REQ-022 owner SHALL update only at a grant and hold its value otherwise.

Reset
REQ-023 When rst_n is low at a rising edge, the module SHALL apply these values at that edge, regardless of state:
- state = IDLE
- cnt = Min
- gnt = 0, done = 0, busy = 0, owner = 0
- round-robin priority restored to requester 0.
REQ-024 A burst in progress when reset is applied SHALL be discarded, with no done pulse.
REQ-025 With rst_n high, no state SHALL change except by clock edge.

Verification
REQ-026 Single burst: reset; req=01, dir0=1, len0=3 -> gnt=01 for 1 cycle; cnt 0,1,2,3; done=01 for 1 cycle; busy falls after DONE.
REQ-027 Wrap: cnt=14; req=10, dir1=1, len1=4 -> cnt 15,0,1,2. Then dir1=0, len1=3 -> cnt 1,0,15.
REQ-028 Contention: req=11 held from reset, len0=len1=1 -> grants alternate 01,10,01,10; each done matches the preceding grant.
REQ-029 Zero length: req=01, len0=0 -> gnt=01, then done=01 on the next cycle; cnt unchanged.
REQ-030 Mid-burst change: after grant with len0=5, drop req and flip dir0 -> all 5 steps complete in the original direction.
REQ-031 Reset mid-RUN: rst_n low at 3rd step -> next cycle cnt=Min, busy=0, no done; req=11 then grants requester 0 first.

Source files
------------

// File: rtl/cnt_sched.sv
// Round-robin burst scheduler driving a shared wrap-around counter.
// Two requesters compete for the counter; the winner's direction and
// length are latched at grant time and the burst runs to completion.
module cnt_sched #(
    parameter logic [3:0] Max = 4'd15,
    parameter logic [3:0] Min = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       owner,
    output logic [3:0] cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rem;
    logic       dir_q;
    logic       last;
    logic       zero_wait;
    logic       accept;
    logic       winner;
    logic       win_dir;
    logic [3:0] win_len;
    logic [3:0] cnt_step;

    // Arbitration: a lone requester wins; on contention the one not
    // granted last wins. 'last' resets to 1 so requester 0 goes first.
    always_comb begin
        accept  = (state == IDLE) && (req != 2'b00);
        winner  = (req == 2'b11) ? ~last : req[1];
        win_dir = winner ? dir1 : dir0;
        win_len = winner ? len1 : len0;
    end

    // Next counter value for one step in the latched direction, wrapping
    // between Min and Max.
    always_comb begin
        cnt_step = cnt;
        if (dir_q) begin
            cnt_step = (cnt == Max) ? Min : cnt + 4'd1;
        end else begin
            cnt_step = (cnt == Min) ? Max : cnt - 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A zero-length burst dwells in DONE for an extra
    // cycle so its done pulse lands after, not on top of, the grant.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (win_len != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (rem <= 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!zero_wait) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the burst at grant, step the counter while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= Min;
            rem       <= 4'd0;
            dir_q     <= 1'b0;
            owner     <= 1'b0;
            last      <= 1'b1;
            gnt       <= 2'b00;
            zero_wait <= 1'b0;
        end else begin
            gnt <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= winner;
                        last      <= winner;
                        dir_q     <= win_dir;
                        rem       <= win_len;
                        gnt       <= winner ? 2'b10 : 2'b01;
                        zero_wait <= (win_len == 4'd0);
                    end
                end
                RUN: begin
                    cnt <= cnt_step;
                    rem <= rem - 4'd1;
                end
                DONE: begin
                    zero_wait <= 1'b0;
                end
                default: begin
                    zero_wait <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy = (state != IDLE);
        done = 2'b00;
        if ((state == DONE) && !zero_wait) begin
            done = owner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched: stimulus pushes expected grant, counter
// and done events; a monitor pops and compares them as the DUT shows them.
module tb_cnt_sched;

    localparam int EV_GNT  = 0;
    localparam int EV_CNT  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int         kind;
        logic [3:0] val;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       dir0;
    logic       dir1;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       owner;
    logic [3:0] cnt;

    ev_t        exp_q[$];
    int         assert_count = 0;
    int         fail_count   = 0;
    int         gnt_seen     = 0;
    bit         mon_en       = 0;
    logic [3:0] prev_cnt     = 4'd0;

    cnt_sched #(.Max(4'd15), .Min(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .dir0  (dir0),
        .dir1  (dir1),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .owner (owner),
        .cnt   (cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic string kind_name(int k);
        if (k == EV_GNT) return "gnt";
        if (k == EV_CNT) return "cnt";
        return "done";
    endfunction

    task automatic push_ev(input int kind, input logic [3:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic check_event(input int kind, input logic [3:0] val);
        ev_t e;
        assert_count++;
        if (exp_q.size() == 0) begin
            fail_count++;
            $display("[TB] FAIL unexpected_%s: got %0d, required no event",
                     kind_name(kind), val);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != kind) || (e.val !== val)) begin
                fail_count++;
                $display("[TB] FAIL event: got %s=%0d, required %s=%0d",
                         kind_name(kind), val, kind_name(e.kind), e.val);
            end
        end
    endtask

    // Monitor: samples 1ns after each rising edge and reports grant,
    // counter change and done events in that order.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (gnt != 2'b00) begin
                    gnt_seen++;
                    check_event(EV_GNT, {2'b00, gnt});
                end
                if (cnt !== prev_cnt) begin
                    check_event(EV_CNT, cnt);
                end
                if (done != 2'b00) begin
                    check_event(EV_DONE, {2'b00, done});
                    check_output("gnt_done_overlap", {30'd0, gnt}, 32'd0);
                end
            end
            prev_cnt = cnt;
        end
    end

    // Drive one request at a falling edge, let it be accepted, then drop req.
    task automatic apply_stimulus(input logic [1:0] r, input logic d0,
                                  input logic [3:0] l0, input logic d1,
                                  input logic [3:0] l1);
        @(negedge clk);
        req  = r;
        dir0 = d0;
        len0 = l0;
        dir1 = d1;
        len1 = l1;
        @(posedge clk);
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_output("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req   = 2'b00;
        dir0  = 1'b0;
        dir1  = 1'b0;
        len0  = 4'd0;
        len1  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_cnt",   {28'd0, cnt},   32'd0);
        check_output("rst_gnt",   {30'd0, gnt},   32'd0);
        check_output("rst_done",  {30'd0, done},  32'd0);
        check_output("rst_busy",  {31'd0, busy},  32'd0);
        check_output("rst_owner", {31'd0, owner}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1;

        $display("[TB] single burst up, len 3");
        push_ev(EV_GNT, 4'd1);
        for (int v = 1; v <= 3; v++) push_ev(EV_CNT, 4'(v));
        push_ev(EV_DONE, 4'd1);
        apply_stimulus(2'b01, 1'b1, 4'd3, 1'b0, 4'd0);
        wait_idle();
        check_output("burst1_cnt",  {28'd0, cnt},  32'd3);
        check_output("burst1_busy", {31'd0, busy}, 32'd0);

        $display("[TB] move counter to 14");
        push_ev(EV_GNT, 4'd1);
        for (int v = 4; v <= 14; v++) push_ev(EV_CNT, 4'(v));
        push_ev(EV_DONE, 4'd1);
        apply_stimulus(2'b01, 1'b1, 4'd11, 1'b0, 4'd0);
        wait_idle();

        $display("[TB] wrap up through Max");
        push_ev(EV_GNT, 4'd2);
        push_ev(EV_CNT, 4'd15);
        push_ev(EV_CNT, 4'd0);
        push_ev(EV_CNT, 4'd1);
        push_ev(EV_CNT, 4'd2);
        push_ev(EV_DONE, 4'd2);
        apply_stimulus(2'b10, 1'b0, 4'd0, 1'b1, 4'd4);
        wait_idle();
        check_output("wrap_owner", {31'd0, owner}, 32'd1);

        $display("[TB] wrap down through Min");
        push_ev(EV_GNT, 4'd2);
        push_ev(EV_CNT, 4'd1);
        push_ev(EV_CNT, 4'd0);
        push_ev(EV_CNT, 4'd15);
        push_ev(EV_DONE, 4'd2);
        apply_stimulus(2'b10, 1'b0, 4'd0, 1'b0, 4'd3);
        wait_idle();

        $display("[TB] zero length burst");
        push_ev(EV_GNT, 4'd1);
        push_ev(EV_DONE, 4'd1);
        apply_stimulus(2'b01, 1'b1, 4'd0, 1'b0, 4'd0);
        wait_idle();
        check_output("zero_cnt",   {28'd0, cnt},   32'd15);
        check_output("zero_owner", {31'd0, owner}, 32'd0);

        $display("[TB] inputs changed mid-burst");
        push_ev(EV_GNT, 4'd1);
        for (int v = 0; v <= 4; v++) push_ev(EV_CNT, 4'(v));
        push_ev(EV_DONE, 4'd1);
        apply_stimulus(2'b01, 1'b1, 4'd5, 1'b0, 4'd0);
        dir0 = 1'b0;
        len0 = 4'd2;
        wait_idle();

        $display("[TB] reset during run");
        push_ev(EV_GNT, 4'd1);
        push_ev(EV_CNT, 4'd5);
        push_ev(EV_CNT, 4'd6);
        apply_stimulus(2'b01, 1'b1, 4'd5, 1'b0, 4'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("pre_reset_queue", exp_q.size(), 32'd0);
        mon_en = 0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("midrst_cnt",   {28'd0, cnt},   32'd0);
        check_output("midrst_busy",  {31'd0, busy},  32'd0);
        check_output("midrst_done",  {30'd0, done},  32'd0);
        check_output("midrst_owner", {31'd0, owner}, 32'd0);

        $display("[TB] contention after reset");
        for (int v = 1; v <= 4; v++) begin
            push_ev(EV_GNT, (v % 2 == 1) ? 4'd1 : 4'd2);
            push_ev(EV_CNT, 4'(v));
            push_ev(EV_DONE, (v % 2 == 1) ? 4'd1 : 4'd2);
        end
        rst_n  = 1'b1;
        req    = 2'b11;
        dir0   = 1'b1;
        dir1   = 1'b1;
        len0   = 4'd1;
        len1   = 4'd1;
        mon_en = 1;
        base   = gnt_seen;
        for (int i = 0; i < 40; i++) begin
            if (gnt_seen >= base + 4) break;
            @(negedge clk);
        end
        check_output("contention_grants", gnt_seen - base, 32'd4);
        req = 2'b00;
        wait_idle();

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check_output("final_queue", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
